// File: rtl/rf_pkg.sv
// Shared types for the register-file write path: address type, grant encoding
// and the arbiter's priority state.
package rf_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_DBG, GNT_WB, GNT_LLU} wr_grant_e;

  typedef enum logic [0:0] {ARB_NORMAL = 1'b0, ARB_STARVED = 1'b1} arb_state_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request side of the register-file write port: WB, LLU and debug writers plus
// the LLU issue notification that arms the busy scoreboard.
interface regfile_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int XLEN = rf_pkg::XLEN
);
  // Each writer raises *_valid with rd/data stable and holds them until its
  // *_ready is seen high; the write happens in that valid&&ready cycle.
  logic            wb_valid;
  reg_addr_t       wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;

  logic            llu_issue;
  reg_addr_t       llu_issue_rd;
  logic            llu_valid;
  reg_addr_t       llu_rd;
  logic [XLEN-1:0] llu_data;
  logic            llu_ready;

  logic            dbg_valid;
  reg_addr_t       dbg_rd;
  logic [XLEN-1:0] dbg_data;
  logic            dbg_ready;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    output dbg_valid, dbg_rd, dbg_data,
    input  wb_ready, llu_ready, dbg_ready
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    input  dbg_valid, dbg_rd, dbg_data,
    output wb_ready, llu_ready, dbg_ready
  );
endinterface

// File: rtl/regfile_busy_tracker.sv
// Scoreboard of registers awaiting a long-latency result. A new issue in the
// same cycle as the retiring write to that register keeps the bit set.
module regfile_busy_tracker
  import rf_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set_en,
  input  reg_addr_t        i_set_rd,
  input  logic             i_clr_en,
  input  reg_addr_t        i_clr_rd,
  output logic [NREGS-1:0] o_busy_mask
);
  logic [NREGS-1:0] r_mask;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_en) w_set[i_set_rd] = 1'b1;
    if (i_clr_en) w_clr[i_clr_rd] = 1'b1;
    w_set[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_mask <= '0;
    else       r_mask <= (r_mask & ~w_clr) | w_set;
  end

  assign o_busy_mask = r_mask;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by debug, writeback and the LLU, with
// starvation promotion for the LLU and a busy mask for the hazard unit.
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN         = rf_pkg::XLEN,
  parameter int NREGS        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  regfile_write_arbiter_if.slave              bus,
  output logic                                rf_we,
  output reg_addr_t                           rf_rd,
  output logic [XLEN-1:0]                     rf_wdata,
  output logic [NREGS-1:0]                    busy_mask,
  output logic [0:0]                          o_dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   o_dbg_scnt
);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_LIMIT);
  localparam logic [0:0] ST_NORMAL  = ARB_NORMAL;
  localparam logic [0:0] ST_STARVED = ARB_STARVED;

  logic [0:0]        r_state;
  logic [SCNT_W-1:0] r_scnt;
  logic [SCNT_W-1:0] w_scnt_nxt;
  wr_grant_e         w_gnt;
  reg_addr_t         w_rd;
  logic [XLEN-1:0]   w_data;
  logic              w_llu_xfer;
  logic              w_llu_wait;

  // Debug always wins; STARVED swaps WB and LLU. Nothing is granted in reset.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!reset) begin
      if (bus.dbg_valid)             w_gnt = GNT_DBG;
      else if (r_state == ST_STARVED) begin
        if (bus.llu_valid)           w_gnt = GNT_LLU;
        else if (bus.wb_valid)       w_gnt = GNT_WB;
      end else begin
        if (bus.wb_valid)            w_gnt = GNT_WB;
        else if (bus.llu_valid)      w_gnt = GNT_LLU;
      end
    end
  end

  assign bus.dbg_ready = (w_gnt == GNT_DBG);
  assign bus.wb_ready  = (w_gnt == GNT_WB);
  assign bus.llu_ready = (w_gnt == GNT_LLU);

  always_comb begin
    w_rd   = '0;
    w_data = '0;
    case (w_gnt)
      GNT_DBG: begin w_rd = bus.dbg_rd; w_data = bus.dbg_data; end
      GNT_WB:  begin w_rd = bus.wb_rd;  w_data = bus.wb_data;  end
      GNT_LLU: begin w_rd = bus.llu_rd; w_data = bus.llu_data; end
      default: begin w_rd = '0;         w_data = '0;           end
    endcase
  end

  assign rf_we    = (w_gnt != GNT_NONE) && (w_rd != '0);
  assign rf_rd    = rf_we ? w_rd : '0;
  assign rf_wdata = rf_we ? w_data : '0;

  assign w_llu_xfer = (w_gnt == GNT_LLU);
  assign w_llu_wait = bus.llu_valid && !w_llu_xfer;
  assign w_scnt_nxt = !w_llu_wait ? '0 :
                      (r_scnt == SCNT_MAX) ? r_scnt : r_scnt + 1'b1;

  // Promotion takes effect on the edge where the count reaches the limit, so the
  // LLU is granted in the cycle after its STARVE_LIMIT-th wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NORMAL;
      r_scnt  <= '0;
    end else begin
      r_scnt <= w_scnt_nxt;
      case (r_state)
        ST_NORMAL:
          if (w_llu_wait && (w_scnt_nxt == SCNT_MAX)) r_state <= ST_STARVED;
        ST_STARVED:
          if (w_llu_xfer || !bus.llu_valid) r_state <= ST_NORMAL;
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  assign o_dbg_state = r_state;
  assign o_dbg_scnt  = r_scnt;

  regfile_busy_tracker #(.NREGS(NREGS)) u_busy (
    .clk         (clk),
    .reset       (reset),
    .i_set_en    (bus.llu_issue),
    .i_set_rd    (bus.llu_issue_rd),
    .i_clr_en    (w_llu_xfer),
    .i_clr_rd    (bus.llu_rd),
    .o_busy_mask (busy_mask)
  );
endmodule
